// File: rtl/smbus_arbiter.sv
// Round-robin arbiter sharing one SMBus master byte stream between NREQ requesters.
// A grant lasts from open rise to open fall, then waits out the master's stop and an idle guard.
module smbus_arbiter #(
  parameter int NREQ         = 2,
  parameter int GUARD_CYCLES = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              quiesce,
  input  logic [8*NREQ-1:0] req_smb_tdata,
  input  logic [NREQ-1:0]   req_smb_tvalid,
  output logic [NREQ-1:0]   req_smb_tready,
  input  logic [NREQ-1:0]   req_smb_open,
  output logic [7:0]        rsp_smb_tdata,
  output logic [NREQ-1:0]   rsp_smb_tvalid,
  output logic [7:0]        m_smb_tdata,
  output logic              m_smb_tvalid,
  input  logic              m_smb_tready,
  output logic              m_smb_open,
  input  logic [7:0]        s_smb_tdata,
  input  logic              s_smb_tvalid,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);

  localparam int unsigned N  = NREQ;
  localparam int unsigned LW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE, S_GUARD} state_t;

  state_t          r_state, w_state_nxt;
  logic [NREQ-1:0] r_grant, w_grant_nxt;
  logic [LW-1:0]   r_last,  w_last_nxt;
  logic [7:0]      r_guard, w_guard_nxt;
  logic            r_rel,   w_rel_nxt;
  logic [7:0]      r_rsp_data;
  logic [NREQ-1:0] r_rsp_valid;
  logic            w_found;
  logic [LW-1:0]   w_cand, w_pick;
  logic            w_granted;

  always_ff @(posedge ap_clk) begin
    if (ap_rst || quiesce) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_last      <= LW'(N - 1);
      r_guard     <= '0;
      r_rel       <= 1'b0;
      r_rsp_valid <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_last      <= w_last_nxt;
      r_guard     <= w_guard_nxt;
      r_rel       <= w_rel_nxt;
      // Read bytes follow the owner through RELEASE/GUARD; nothing is routed while idle.
      r_rsp_valid <= (r_state != S_IDLE && s_smb_tvalid) ? r_grant : '0;
    end
  end

  always_ff @(posedge ap_clk) begin
    r_rsp_data <= s_smb_tdata;
  end

  // Round-robin pick: first open requester after the previous owner, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    w_cand  = r_last;
    for (int unsigned i = 1; i <= N; i++) begin
      w_cand = LW'((32'(r_last) + i) % N);
      if (!w_found && req_smb_open[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_guard_nxt = r_guard;
    w_rel_nxt   = r_rel;

    w_granted      = (r_state == S_GRANT);
    m_smb_open     = w_granted & req_smb_open[r_last];
    m_smb_tvalid   = w_granted & req_smb_tvalid[r_last];
    m_smb_tdata    = req_smb_tdata[{r_last, 3'b000} +: 8];
    req_smb_tready = '0;
    if (w_granted) req_smb_tready[r_last] = m_smb_tready;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt         = S_GRANT;
          w_grant_nxt         = '0;
          w_grant_nxt[w_pick] = 1'b1;
          w_last_nxt          = w_pick;
        end
      end
      S_GRANT: begin
        if (!req_smb_open[r_last]) begin
          w_state_nxt = S_RELEASE;
          w_guard_nxt = '0;
          w_rel_nxt   = 1'b0;
        end
      end
      S_RELEASE: begin
        // First RELEASE cycle never exits: gives the master time to drop tready for its stop.
        if (r_rel && m_smb_tready) begin
          w_state_nxt = S_GUARD;
          w_guard_nxt = '0;
        end else begin
          w_rel_nxt = 1'b1;
        end
      end
      S_GUARD: begin
        if (!m_smb_tready) begin
          w_guard_nxt = '0;
        end else if (r_guard == 8'(GUARD_CYCLES - 1)) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_guard_nxt = '0;
        end else begin
          w_guard_nxt = r_guard + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign grant          = r_grant;
  assign busy           = (r_state != S_IDLE);
  assign rsp_smb_tdata  = r_rsp_data;
  assign rsp_smb_tvalid = r_rsp_valid;

  grant_onehot0: assert property (@(posedge ap_clk) $onehot0(r_grant));

endmodule

// File: doc/smbus_arbiter.md
Name: smbus_arbiter

Overview:
- Shares the single SMBus master byte-stream port (from_host/to_host smb streams plus open) between NREQ requesters, e.g. the host Xillybus pipe and an on-chip sensor poller.
- Grants one requester for a whole transaction, from its open rising to its open falling, and forwards that requester's bytes downstream.
- Routes returned read bytes back to the granted requester only.
- Holds off the next grant until the master has finished its stop condition and the bus has been idle for a guard time.

Parameters:
- NREQ, 2, number of requesters (2..8).
- GUARD_CYCLES, 16, consecutive ap_clk cycles with m_smb_tready high required after a release before a new grant (1..255).

Ports:
- ap_clk  in  1  clock.
- ap_rst  in  1  synchronous, active-high reset.
- quiesce  in  1  forces release, same effect as reset on state and grant.
- req_smb_tdata  in  8*NREQ  requester i byte at bits [8i+7:8i].
- req_smb_tvalid  in  NREQ  per-requester byte valid.
- req_smb_tready  out  NREQ  per-requester byte accepted.
- req_smb_open  in  NREQ  transaction request/hold; falling edge ends the transaction.
- rsp_smb_tdata  out  8  returned byte, shared by all requesters.
- rsp_smb_tvalid  out  NREQ  one-hot strobe marking which requester owns rsp_smb_tdata.
- m_smb_tdata  out  8  to master from_host_smb_tdata.
- m_smb_tvalid  out  1  to master.
- m_smb_tready  in  1  from master.
- m_smb_open  out  1  to master from_host_smb_open.
- s_smb_tdata  in  8  from master to_host_smb_tdata.
- s_smb_tvalid  in  1  from master; no backpressure.
- grant  out  NREQ  one-hot current owner, 0 when none.
- busy  out  1  state != IDLE.

Behaviour:
- Reset / quiesce values:
  - state=IDLE, grant=0, last=NREQ-1, guard count=0.
  - m_smb_open=0, m_smb_tvalid=0, req_smb_tready=0, rsp_smb_tvalid=0.
- States: IDLE, GRANT, RELEASE, GUARD.
- IDLE:
  - Candidate set is the req_smb_open bits.
  - Round-robin search starts at last+1 and wraps modulo NREQ.
  - If any candidate exists, register grant[k]=1, set last=k, go to GRANT next cycle.
  - Latency from open rising to grant is 1 cycle.
- GRANT (owner g):
  - m_smb_open = req_smb_open[g].
  - m_smb_tdata = req_smb_tdata[g]; m_smb_tvalid = req_smb_tvalid[g].
  - req_smb_tready[g] = m_smb_tready. The path is combinational; no data registering.
  - Non-owners see tready=0. Their bytes stay held, never dropped.
  - When req_smb_open[g]=0 is sampled, go to RELEASE, clear the guard count, and take m_smb_open low in the same cycle.
  - Any byte handshake in that same cycle still completes. The master flushes it before its stop.
- RELEASE:
  - m_smb_open=0, m_smb_tvalid=0, all tready=0. grant stays g.
  - Wait at least 2 cycles, so the master's stop_pending is set and its tready falls.
  - Then go to GUARD on the first cycle m_smb_tready=1.
- GUARD:
  - Count consecutive m_smb_tready=1 cycles; a cycle with m_smb_tready=0 resets the count.
  - At GUARD_CYCLES, set grant=0 and go to IDLE.
  - The owner's open re-rising in RELEASE or GUARD is ignored until IDLE. It then competes normally under round-robin.
- Responses:
  - rsp_smb_tdata = s_smb_tdata, registered, 1-cycle latency.
  - rsp_smb_tvalid[g] = s_smb_tvalid, registered, while state is GRANT, RELEASE or GUARD. Late read bytes therefore still reach the owner.
  - s_smb_tvalid in IDLE is discarded and rsp_smb_tvalid stays 0.
- Simultaneous requests in IDLE: exactly one grant per transaction, in round-robin order. No requester is starved; each waits at most NREQ-1 transactions.
- Open falling on the same cycle as the grant registers: the owner gets GRANT for one cycle, then RELEASE. m_smb_open pulses 0 and no bytes are sent.
- Reset or quiesce mid-transaction: m_smb_open drops immediately, no grant is held, and the master's own quiesce is expected together with it.
- grant is always one-hot or zero (assertion).

Test Plan:
- Req0 opens, sends 0xA0, 0x10, closes; master model tready follows its byte cycle → m_smb_tdata A0,10 in order; grant=01 until 16 idle-ready cycles after close.
- Req0 and req1 open on the same cycle from reset (last=1) → req0 granted first. Req1 tready=0 throughout; req1 is granted after the guard expires; m_smb_open low for ≥18 cycles between transactions.
- Read: req1 sends 0xA1 then dummy bytes; master returns 0x5C, 0x3E → rsp_smb_tvalid=10 with data 5C, 3E; rsp_smb_tvalid[0] never set.
- Read byte strobed 3 cycles after req1 closes (RELEASE) → still delivered to req1. s_smb_tvalid in IDLE → no rsp strobe.
- Master tready dips low during GUARD at count 10 → count restarts; grant released only after 16 consecutive high cycles.
- quiesce pulse while req0 is mid-transaction with a byte pending → next cycle m_smb_open=0, grant=0, req0 tready=0; req0 re-open → re-granted 1 cycle later.
